evict_buffer: RTL and testbench
===============================

Name: evict_buffer

Overview:
- Write-back eviction buffer between the LC-3b L1 cache datapath and physical memory.
- The cache controller pushes dirty victim lines (line address + 128-bit line) into a small FIFO, then continues its fill without waiting for the write-back.
- An internal drain FSM writes buffered lines to pmem in push order using the pmem_write/pmem_resp handshake.
- Optional lookup port forwards a buffered line to the cache on an address match.

Parameters:
DEPTH, 4, number of buffered lines; power of two, minimum 2
width, 128, line width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
push  input  1  cache requests enqueue of a victim line this cycle
push_addr  input  16  victim line byte address; bits [3:0] ignored
push_data  input  width  victim line data
full  output  1  buffer holds DEPTH entries; a push is ignored while high
empty  output  1  buffer holds no entries and drain FSM is IDLE
count  output  $clog2(DEPTH)+1  number of valid entries
pmem_write  output  1  write request to physical memory
pmem_address  output  16  line address of head entry, bits [3:0] = 0
pmem_wdata  output  width  data of head entry
pmem_resp  input  1  memory completed the current write
lookup_addr  input  16  cache miss address to check (feature only)
lookup_hit  output  1  a buffered entry matches lookup_addr[15:4]
lookup_data  output  width  data of the matching entry

Behaviour:
- Reset: all entries invalid; head/tail pointers = 0; count = 0; full = 0; empty = 1; state = IDLE; pmem_write = 0; pmem_address = 0; pmem_wdata = 0; lookup_hit = 0.
- Storage: circular array of DEPTH entries {addr[15:4], data}. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: push && !full writes the entry at tail and increments tail and count at the clock edge. Push when full is dropped silently; the controller must check full first.
- full is derived from the registered count. When full, a push is refused even if pmem_resp pops an entry in the same cycle.
- Drain FSM states:
  - IDLE: pmem_write = 0. If count != 0, go to WRITE next cycle.
  - WRITE: pmem_write = 1; pmem_address = {head.addr, 4'b0}; pmem_wdata = head.data. Address and data are held stable until pmem_resp.
  - On pmem_resp in WRITE: pop the head (head+1, count-1) and return to IDLE. This gives a mandatory one-cycle pmem_write low gap between writes.
  - pmem_resp outside WRITE is ignored.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- A push while count == 0 and IDLE: the entry appears in WRITE two cycles after the push cycle (push edge, then IDLE to WRITE edge).
- Duplicate addresses are stored separately and drained in push order.
- Reset mid-WRITE: the in-flight write is abandoned, pmem_write is low after the reset edge, and all entries are lost.
- pmem outputs are driven from state and the head entry; no combinational path from push to pmem_*.
- empty = (count == 0) && state == IDLE.

Optional Feature:
- Macro EVICT_BUFFER_FWD_EN.
- Defined:
  - lookup_hit = any valid entry with addr == lookup_addr[15:4], including the head currently being written.
  - lookup_data = data of the youngest matching entry (nearest to tail).
  - Purely combinational, same cycle as lookup_addr.
- Undefined:
  - lookup_hit = 0 and lookup_data = 0.
  - The cache controller must wait for empty = 1 before issuing any pmem read.

Decomposition:
- Add to lc3b_types: lc3b_c_line (128-bit), lc3b_c_tagaddr (16:4 slice width, 12 bits), and an evb_state_t enum {EVB_IDLE, EVB_WRITE}.
- One sub-module, evict_fifo: the circular storage plus pointers and count, with push/pop/head read.
- The top level holds the drain FSM and the lookup compare.

Test Plan:
- Reset, then a single push of addr 0x1234, data D0 -> two cycles later pmem_write=1, pmem_address=0x1230, wdata=D0. Hold pmem_resp low 5 cycles -> outputs stable. Assert resp -> count=0, pmem_write=0 next cycle, empty=1.
- Push 4 lines (0x1000, 0x2000, 0x3000, 0x4000) back-to-back with pmem_resp never asserted -> full=1 after the 4th. A 5th push is ignored, count stays 4, and writes later drain in the order 0x1000..0x4000.
- Buffer full, push and pmem_resp in the same cycle -> push refused, count=3.
  - Count=2 with the same push+resp -> count stays 2, tail and head advance.
  - Repeat until the pointers wrap at least twice; drained data matches push order.
- Reset asserted mid-WRITE with 3 entries -> pmem_write=0 after the edge, count=0, empty=1, and no further writes.
- EVICT_BUFFER_FWD_EN:
  - Push 0x5000/DA, then 0x5000/DB, then lookup 0x500C -> hit=1, data=DB.
  - Lookup 0x6000 -> hit=0.
  - Without the macro -> hit=0 for all lookups.

Source files
------------

// File: rtl/evict_buffer_pkg.sv
// Shared LC-3b cache types for the write-back eviction buffer.
// Line, tag-address and drain FSM state definitions.
package evict_buffer_pkg;

  localparam int LINE_W = 128;
  localparam int TAG_W  = 12;

  typedef logic [LINE_W-1:0] lc3b_c_line;
  typedef logic [TAG_W-1:0]  lc3b_c_tagaddr;

  typedef enum logic {
    EVB_IDLE,
    EVB_WRITE
  } evb_state_t;

endpackage

// File: rtl/evict_fifo.sv
// Circular storage for evicted lines: tag + data per slot,
// head/tail pointers, entry count and per-slot valid bits.
module evict_fifo
  import evict_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int width = 128,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [TAG_W-1:0]              push_tag,
  input  logic [width-1:0]              push_data,
  input  logic                          pop,
  output logic                          full,
  output logic [CW-1:0]                 count,
  output logic [PW-1:0]                 head,
  output logic [DEPTH-1:0]              valid,
  output logic [DEPTH-1:0][TAG_W-1:0]   tags,
  output logic [DEPTH-1:0][width-1:0]   datas,
  output logic [TAG_W-1:0]              head_tag,
  output logic [width-1:0]              head_data
);

  logic [PW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  // full comes from the registered count, so a same-cycle pop never frees a slot
  assign full      = (count == CW'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && (count != '0);
  assign head_tag  = tags[head];
  assign head_data = datas[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (do_push) begin
        valid[tail] <= 1'b1;
        tags[tail]  <= push_tag;
        datas[tail] <= push_data;
        tail        <= tail + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/evict_buffer.sv
// Write-back eviction buffer: FIFO of dirty lines drained to pmem in order.
// Optional forwarding lookup enabled by EVICT_BUFFER_FWD_EN.
module evict_buffer
  import evict_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int width = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [15:0]              push_addr,
  input  logic [width-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pmem_write,
  output logic [15:0]              pmem_address,
  output logic [width-1:0]         pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [15:0]              lookup_addr,
  output logic                     lookup_hit,
  output logic [width-1:0]         lookup_data
);

  localparam int PW = $clog2(DEPTH);

  evb_state_t                    state_q;
  evb_state_t                    state_d;
  logic                          pop;
  logic [PW-1:0]                 head;
  logic [DEPTH-1:0]              valid;
  logic [DEPTH-1:0][TAG_W-1:0]   tags;
  logic [DEPTH-1:0][width-1:0]   datas;
  lc3b_c_tagaddr                 head_tag;
  logic [width-1:0]              head_data;
  logic                          unused_lo;

  assign unused_lo = ^push_addr[3:0];

  evict_fifo #(
    .DEPTH (DEPTH),
    .width (width)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_tag  (push_addr[15:4]),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .count     (count),
    .head      (head),
    .valid     (valid),
    .tags      (tags),
    .datas     (datas),
    .head_tag  (head_tag),
    .head_data (head_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= EVB_IDLE;
    else     state_q <= state_d;
  end

  // IDLE always lasts a cycle, leaving a pmem_write gap between lines
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      EVB_IDLE: begin
        if (count != '0) state_d = EVB_WRITE;
      end
      EVB_WRITE: begin
        if (pmem_resp) begin
          pop     = 1'b1;
          state_d = EVB_IDLE;
        end
      end
      default: state_d = EVB_IDLE;
    endcase
  end

  assign pmem_write   = (state_q == EVB_WRITE);
  assign pmem_address = pmem_write ? {head_tag, 4'b0000} : '0;
  assign pmem_wdata   = pmem_write ? head_data : '0;
  assign empty        = (count == '0) && (state_q == EVB_IDLE);

`ifdef EVICT_BUFFER_FWD_EN
  lc3b_c_tagaddr  look_tag;
  logic [PW-1:0]  idx;
  logic           unused_fwd;

  assign look_tag   = lookup_addr[15:4];
  assign unused_fwd = ^lookup_addr[3:0];

  // walk oldest to youngest so the last match is the newest copy
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (tags[idx] == look_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = datas[idx];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd  = ^{lookup_addr, valid, tags, datas, head};
  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;
`endif

endmodule

// File: tb/tb_evict_buffer.sv
// Randomized + directed bench for evict_buffer against a queue model.
module tb_evict_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [15:0]   push_addr;
  logic [W-1:0]  push_data;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [W-1:0]  pmem_wdata;
  logic          pmem_resp;
  logic [15:0]   lookup_addr;
  logic          lookup_hit;
  logic [W-1:0]  lookup_data;

  always #5 clk = ~clk;

  evict_buffer #(.DEPTH(DEPTH), .width(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_addr    (push_addr),
    .push_data    (push_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data)
  );

  typedef struct {
    logic [15:0]  a;
    logic [W-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   mwr;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic compare();
    logic [15:0]  ea;
    logic [W-1:0] ed;
    logic         eh;
    logic [W-1:0] ld;
    ea = '0;
    ed = '0;
    eh = 1'b0;
    ld = '0;
    if (mwr) begin
      ea = {q[0].a[15:4], 4'h0};
      ed = q[0].d;
    end
`ifdef EVICT_BUFFER_FWD_EN
    for (int i = 0; i < q.size(); i++)
      if (q[i].a[15:4] == lookup_addr[15:4]) begin
        eh = 1'b1;
        ld = q[i].d;
      end
`endif
    check("pmem_write", W'(pmem_write), W'(mwr));
    check("pmem_address", W'(pmem_address), W'(ea));
    check("pmem_wdata", pmem_wdata, ed);
    check("count", W'(count), W'(q.size()));
    check("full", W'(full), W'(q.size() == DEPTH));
    check("empty", W'(empty), W'(q.size() == 0 && !mwr));
    check("lookup_hit", W'(lookup_hit), W'(eh));
    check("lookup_data", lookup_data, ld);
  endtask

  task automatic model_edge();
    int n;
    bit pop;
    n   = q.size();
    pop = mwr && pmem_resp;
    if (rst) begin
      q.delete();
      mwr = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push && n < DEPTH) q.push_back('{push_addr, push_data});
      mwr = mwr ? !pop : (n != 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    push = 1'b0;
    for (int i = 0; i < 100 && !(q.size() == 0 && !mwr); i++) begin
      pmem_resp = pmem_write;
      tick();
    end
    pmem_resp = 1'b0;
    check("drain_done", W'(empty), W'(1));
  endtask

  logic [W-1:0] d0;
  logic [W-1:0] da;
  logic [W-1:0] db;
  logic [15:0]  got[$];
  logic [15:0]  exp_order[3];
  logic [15:0]  tmp;
  bit           pp;

  initial begin
    rst         = 1'b1;
    push        = 1'b0;
    push_addr   = '0;
    push_data   = '0;
    pmem_resp   = 1'b0;
    lookup_addr = 16'hFFF0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    mwr = 1'b0;
    rst = 1'b0;
    check("rst_count", W'(count), '0);
    check("rst_full", W'(full), '0);
    check("rst_empty", W'(empty), W'(1));
    check("rst_write", W'(pmem_write), '0);
    check("rst_addr", W'(pmem_address), '0);
    check("rst_wdata", pmem_wdata, '0);
    check("rst_hit", W'(lookup_hit), '0);

    // single line, two-cycle latency, held through a slow response
    d0        = rnd128();
    push      = 1'b1;
    push_addr = 16'h1234;
    push_data = d0;
    tick();
    push = 1'b0;
    tick();
    check("t1_write", W'(pmem_write), W'(1));
    check("t1_addr", W'(pmem_address), W'(16'h1230));
    check("t1_wdata", pmem_wdata, d0);
    repeat (5) tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("t1_count", W'(count), '0);
    check("t1_gap", W'(pmem_write), '0);
    check("t1_empty", W'(empty), W'(1));

    // fill, overflow push, refused push with concurrent pop
    for (int i = 1; i <= 4; i++) begin
      push      = 1'b1;
      push_addr = 16'(i) << 12;
      push_data = rnd128();
      tick();
    end
    push = 1'b0;
    check("t2_full", W'(full), W'(1));
    push      = 1'b1;
    push_addr = 16'h5550;
    push_data = rnd128();
    tick();
    push = 1'b0;
    check("t2_count4", W'(count), W'(4));
    check("t2_wr", W'(pmem_write), W'(1));
    push      = 1'b1;
    push_addr = 16'h9990;
    pmem_resp = 1'b1;
    tick();
    push      = 1'b0;
    pmem_resp = 1'b0;
    check("t2_count3", W'(count), W'(3));
    exp_order = '{16'h2000, 16'h3000, 16'h4000};
    got.delete();
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      pmem_resp = pmem_write;
      if (pmem_write) got.push_back(pmem_address);
      tick();
    end
    pmem_resp = 1'b0;
    check("t2_ndrain", W'(got.size()), W'(3));
    for (int i = 0; i < 3 && i < got.size(); i++)
      check("t2_order", W'(got[i]), W'(exp_order[i]));
    drain_all();

    // steady push+pop at count 2 until pointers wrap
    for (int i = 0; i < 2; i++) begin
      push      = 1'b1;
      push_addr = 16'($urandom_range(0, 65535));
      push_data = rnd128();
      tick();
    end
    push = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pp        = pmem_write;
      push      = pp;
      pmem_resp = pp;
      push_addr = 16'($urandom_range(0, 65535));
      push_data = rnd128();
      tick();
      if (pp) check("t3_count2", W'(count), W'(2));
    end
    push      = 1'b0;
    pmem_resp = 1'b0;
    drain_all();

    // reset during an in-flight write
    for (int i = 0; i < 3; i++) begin
      push      = 1'b1;
      push_addr = 16'h7000 + 16'(i) * 16'h10;
      push_data = rnd128();
      tick();
    end
    push = 1'b0;
    tick();
    check("t4_inflight", W'(pmem_write), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_write", W'(pmem_write), '0);
    check("t4_count", W'(count), '0);
    check("t4_empty", W'(empty), W'(1));
    repeat (4) tick();

    // forwarding lookup of duplicate addresses
    da        = rnd128();
    db        = rnd128();
    push      = 1'b1;
    push_addr = 16'h5000;
    push_data = da;
    tick();
    push_data = db;
    tick();
    push        = 1'b0;
    lookup_addr = 16'h500C;
    #1;
`ifdef EVICT_BUFFER_FWD_EN
    check("t5_hit", W'(lookup_hit), W'(1));
    check("t5_data", lookup_data, db);
`else
    check("t5_hit", W'(lookup_hit), '0);
    check("t5_data", lookup_data, '0);
`endif
    lookup_addr = 16'h6000;
    #1;
    check("t5_miss", W'(lookup_hit), '0);
    tick();
    drain_all();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      push        = ($urandom_range(0, 1) == 1);
      tmp         = 16'($urandom_range(0, 5)) << 12;
      push_addr   = tmp | 16'($urandom_range(0, 15));
      push_data   = rnd128();
      pmem_resp   = ($urandom_range(0, 1) == 1);
      tmp         = 16'($urandom_range(0, 6)) << 12;
      lookup_addr = tmp | 16'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
